// File: rtl/my_soc_pkg.sv
// Shared constants and types for the UART SoC core: banner bytes, UART FSM
// state encoding and bit-timing helpers.
package my_soc_pkg;

  localparam int BANNER_LEN = 4;
  localparam int DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  // Cycles from the start-bit edge to its middle; data bits are then sampled
  // one full bit period apart, which keeps every sample at mid-bit.
  function automatic int half_bit(input int clks);
    return clks / 2;
  endfunction

  // Boot banner "OK\r\n", sent in index order.
  function automatic logic [7:0] banner_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h4F;
      3'd1:    return 8'h4B;
      3'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

endpackage

// File: rtl/my_soc_uart_rx.sv
// UART 8N1 receiver: 2-flop synchronizer, mid-bit sampling FSM.
// rx_valid and frame_err are single-cycle pulses; rx_byte holds the last
// assembled byte and is valid while rx_valid is high.
module my_soc_uart_rx
  import my_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       frame_err
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST      = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(half_bit(CLKS_PER_BIT) - 1);

  logic [1:0]    sync;
  logic          rx_s;
  uart_state_e   state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [2:0]    bit_idx, bit_idx_nx;
  logic [7:0]    shreg, shreg_nx;
  logic          err_wait, err_wait_nx;
  logic          valid_nx, ferr_nx;

  assign rx_s    = sync[1];
  assign rx_byte = shreg;

  // Synchronizer; resets to the idle line level so no false start follows reset.
  always_ff @(posedge clk) begin
    if (reset) sync <= 2'b11;
    else       sync <= {sync[0], rx_in};
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      err_wait  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      bit_idx   <= bit_idx_nx;
      shreg     <= shreg_nx;
      err_wait  <= err_wait_nx;
      rx_valid  <= valid_nx;
      frame_err <= ferr_nx;
    end
  end

  // RX next state: validate start at mid-bit, shift data LSB first, check stop.
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    bit_idx_nx  = bit_idx;
    shreg_nx    = shreg;
    err_wait_nx = err_wait;
    valid_nx    = 1'b0;
    ferr_nx     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nx = START;
          cnt_nx   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            state_nx = IDLE;          // glitch, not a real start bit
          end else begin
            state_nx   = DATA;
            bit_idx_nx = '0;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == LAST) begin
          cnt_nx   = '0;
          shreg_nx = {rx_s, shreg[7:1]};
          if (bit_idx == 3'(DATA_BITS - 1)) state_nx = STOP;
          else                              bit_idx_nx = bit_idx + 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (err_wait) begin
          // Bad stop bit: hold off until the line idles so the low tail
          // is not mistaken for a new start bit.
          if (rx_s) begin
            state_nx    = IDLE;
            err_wait_nx = 1'b0;
          end
        end else if (cnt == LAST) begin
          cnt_nx = '0;
          if (rx_s) begin
            valid_nx = 1'b1;
            state_nx = IDLE;
          end else begin
            ferr_nx     = 1'b1;
            err_wait_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: rtl/my_soc_core.sv
// Minimal SoC core: sends the "OK\r\n" banner after reset, then echoes every
// correctly framed received byte through a small RX->TX FIFO.
module my_soc_core
  import my_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic uart_rx,
  output logic uart_tx,
  output logic boot_done,
  output logic rx_frame_err,
  output logic rx_overflow
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam int            AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int            CNTW = AW + 1;
  localparam int            BIW  = $clog2(BANNER_LEN + 1);

  // ---------------- receiver ----------------
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_ferr_pulse;

  my_soc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .rx_in     (uart_rx),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (rx_ferr_pulse)
  );

  // ---------------- echo FIFO ----------------
  logic [FIFO_DEPTH-1:0][7:0] mem;
  logic [AW-1:0]              wr_ptr, rd_ptr;
  logic [CNTW-1:0]            count;
  logic                       full, push, pop, ovf_set;

  assign full    = (count == CNTW'(FIFO_DEPTH));
  // A pop in the same cycle frees a slot, so a full FIFO still accepts.
  assign push    = rx_valid && (!full || pop);
  assign ovf_set = rx_valid && full && !pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  // FIFO pointers, occupancy and sticky RX status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      rx_overflow  <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (ovf_set)       rx_overflow  <= 1'b1;
      if (rx_ferr_pulse) rx_frame_err <= 1'b1;
    end
  end

  // ---------------- transmitter + banner sequencer ----------------
  uart_state_e   tx_state, tx_state_nx;
  logic [CW-1:0] tx_cnt, tx_cnt_nx;
  logic [2:0]    tx_bit, tx_bit_nx;
  logic [7:0]    tx_sh, tx_sh_nx;
  logic          tx_out_nx;
  logic [BIW-1:0] banner_idx, banner_idx_nx;
  logic          boot_nx;
  logic          banner_pend, fifo_pend, pend, take;
  logic [7:0]    next_byte;

  // Banner has absolute priority; the FIFO is only served once booted.
  assign banner_pend = !boot_done && (banner_idx < BIW'(BANNER_LEN));
  assign fifo_pend   = boot_done && (count != '0);
  assign pend        = banner_pend || fifo_pend;
  assign next_byte   = banner_pend ? banner_byte(3'(banner_idx)) : mem[rd_ptr];

  // TX state register; uart_tx is registered so it is glitch-free at the pad.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state   <= IDLE;
      tx_cnt     <= '0;
      tx_bit     <= '0;
      tx_sh      <= '0;
      uart_tx    <= 1'b1;
      banner_idx <= '0;
      boot_done  <= 1'b0;
    end else begin
      tx_state   <= tx_state_nx;
      tx_cnt     <= tx_cnt_nx;
      tx_bit     <= tx_bit_nx;
      tx_sh      <= tx_sh_nx;
      uart_tx    <= tx_out_nx;
      banner_idx <= banner_idx_nx;
      boot_done  <= boot_nx;
    end
  end

  // TX next state: frame serialiser; a pending byte is taken from IDLE or
  // straight out of the stop bit so consecutive frames have no idle gap.
  always_comb begin
    tx_state_nx   = tx_state;
    tx_cnt_nx     = tx_cnt;
    tx_bit_nx     = tx_bit;
    tx_sh_nx      = tx_sh;
    tx_out_nx     = uart_tx;
    banner_idx_nx = banner_idx;
    boot_nx       = boot_done;
    pop           = 1'b0;
    take          = 1'b0;
    case (tx_state)
      IDLE: begin
        tx_out_nx = 1'b1;
        take      = pend;
      end
      START: begin
        if (tx_cnt == LAST) begin
          tx_cnt_nx   = '0;
          tx_bit_nx   = '0;
          tx_out_nx   = tx_sh[0];
          tx_state_nx = DATA;
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      DATA: begin
        if (tx_cnt == LAST) begin
          tx_cnt_nx = '0;
          if (tx_bit == 3'(DATA_BITS - 1)) begin
            tx_out_nx   = 1'b1;
            tx_state_nx = STOP;
          end else begin
            tx_bit_nx = tx_bit + 1'b1;
            tx_sh_nx  = {1'b1, tx_sh[7:1]};
            tx_out_nx = tx_sh[1];
          end
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      STOP: begin
        if (tx_cnt == LAST) begin
          tx_cnt_nx = '0;
          // Last banner byte finished: boot is complete from this edge on.
          if (!boot_done && !banner_pend) boot_nx = 1'b1;
          take = pend;
          if (!pend) begin
            tx_state_nx = IDLE;
            tx_out_nx   = 1'b1;
          end
        end else begin
          tx_cnt_nx = tx_cnt + 1'b1;
        end
      end
      default: tx_state_nx = IDLE;
    endcase
    if (take) begin
      tx_state_nx = START;
      tx_cnt_nx   = '0;
      tx_out_nx   = 1'b0;
      tx_sh_nx    = next_byte;
      if (banner_pend) banner_idx_nx = banner_idx + 1'b1;
      else             pop = 1'b1;
    end
  end

endmodule

// File: tb/tb_my_soc_core.sv
// Bench for my_soc_core: two instances (normal FIFO, shallow FIFO for the
// overflow case), a UART line monitor per instance and a byte-level model.
module tb_my_soc_core;

  localparam int C         = 8;
  localparam int HALF      = C / 2;
  localparam int DEPTH     = 4;
  localparam int OVF_DEPTH = 2;
  localparam int BOUND     = 2 + HALF + 9 * C + 2;

  typedef struct {
    int         ln;
    logic [7:0] b;
    int         t;
    logic       ok;
  } frm_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rx_line = 2'b11;
  logic [1:0] tx, boot, ferr, ovf;

  int   cyc = 0;
  int   n_chk = 0, n_err = 0;
  frm_t mon_q[$];

  logic [7:0] banner[4] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

  my_soc_core #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk(clk), .reset(reset), .uart_rx(rx_line[0]), .uart_tx(tx[0]),
    .boot_done(boot[0]), .rx_frame_err(ferr[0]), .rx_overflow(ovf[0])
  );

  my_soc_core #(.CLKS_PER_BIT(C), .FIFO_DEPTH(OVF_DEPTH)) u_ovf (
    .clk(clk), .reset(reset), .uart_rx(rx_line[1]), .uart_tx(tx[1]),
    .boot_done(boot[1]), .rx_frame_err(ferr[1]), .rx_overflow(ovf[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one frame starting at a negedge; the line is left at the stop level.
  task automatic send_byte(input int ln, input logic [7:0] b, input logic stop);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_line[ln] = fr[i];
      repeat (C) @(negedge clk);
    end
  endtask

  task automatic mwait(input int n, inout logic bad);
    for (int k = 0; k < n; k++) begin
      if (!bad) begin
        @(negedge clk);
        if (reset) bad = 1'b1;
      end
    end
  endtask

  // Decode frames on uart_tx; a frame cut by reset is discarded.
  task automatic mon(input int ln);
    frm_t f;
    logic bad;
    forever begin
      @(negedge clk);
      if (!reset && tx[ln] === 1'b0) begin
        f.ln = ln; f.t = cyc; f.ok = 1'b1; f.b = '0; bad = 1'b0;
        mwait(HALF - 1, bad);
        if (tx[ln] !== 1'b0) f.ok = 1'b0;
        for (int i = 0; i < 8; i++) begin
          mwait(C, bad);
          f.b[i] = tx[ln];
        end
        mwait(C, bad);
        if (tx[ln] !== 1'b1) f.ok = 1'b0;
        if (!bad) mon_q.push_back(f);
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  function automatic int n_frames(input int ln);
    int n = 0;
    foreach (mon_q[i]) if (mon_q[i].ln == ln) n++;
    return n;
  endfunction

  task automatic expect_frame(input string tag, input int ln, input logic [7:0] eb,
                              input int budget, output int t);
    int idx;
    idx = -1;
    t   = -1;
    for (int w = 0; w < budget && idx < 0; w++) begin
      @(negedge clk);
      foreach (mon_q[i]) if (idx < 0 && mon_q[i].ln == ln) idx = i;
    end
    if (idx < 0) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_byte"}, {24'd0, mon_q[idx].b}, {24'd0, eb});
      chk({tag, "_framing"}, {31'd0, mon_q[idx].ok}, 32'd1);
      t = mon_q[idx].t;
      mon_q.delete(idx);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [7:0] exp0[$], exp1[$];
    logic [7:0] b;
    int t, t_rel, c0, n1;
    logic exp_ovf1, exp_ferr0, all_high;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    for (int ln = 0; ln < 2; ln++) begin
      chk("rst_tx", {31'd0, tx[ln]}, 32'd1);
      chk("rst_boot", {31'd0, boot[ln]}, 32'd0);
      chk("rst_ferr", {31'd0, ferr[ln]}, 32'd0);
      chk("rst_ovf", {31'd0, ovf[ln]}, 32'd0);
    end

    // ---- banner, bytes buffered during banner, overflow on shallow FIFO ----
    exp0 = {};
    exp1 = {};
    foreach (banner[i]) begin exp0.push_back(banner[i]); exp1.push_back(banner[i]); end
    exp_ovf1 = 1'b0;
    n1 = 0;
    reset = 1'b0;
    t_rel = cyc;
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          b = 8'($urandom);
          exp0.push_back(b);
          send_byte(0, b, 1'b1);
        end
      end
      begin
        logic [7:0] b1;
        for (int k = 0; k < OVF_DEPTH + 1; k++) begin
          b1 = 8'($urandom);
          if (n1 < OVF_DEPTH) exp1.push_back(b1);
          else                exp_ovf1 = 1'b1;
          n1++;
          send_byte(1, b1, 1'b1);
        end
      end
      begin
        @(posedge clk); #1;
        chk("tx_low_first_edge", {31'd0, tx[0]}, 32'd0);
        repeat (319) @(posedge clk); #1;
        chk("boot_early", {30'd0, boot}, 32'd0);
        @(posedge clk); #1;
        chk("boot_at_320", {30'd0, boot}, 32'd3);
      end
    join

    for (int i = 0; i < exp0.size(); i++) begin
      expect_frame("boot_main", 0, exp0[i], 2000, t);
      if (i < 4) chk("banner_start_cyc", t, t_rel + 1 + i * 10 * C);
    end
    foreach (exp1[i]) expect_frame("boot_ovf", 1, exp1[i], 2000, t);
    repeat (20 * C) @(negedge clk);
    chk("ovf_extra_frames", n_frames(1), 0);
    chk("ovf_flag", {31'd0, ovf[1]}, {31'd0, exp_ovf1});
    chk("ovf_no_ferr", {31'd0, ferr[1]}, 32'd0);
    chk("main_no_ovf", {31'd0, ovf[0]}, 32'd0);
    chk("main_no_ferr", {31'd0, ferr[0]}, 32'd0);
    chk("main_extra_frames", n_frames(0), 0);

    // ---- echo with latency bound ----
    for (int k = 0; k < 5; k++) begin
      b = (k == 0) ? 8'hA5 : 8'($urandom);
      c0 = cyc;
      send_byte(0, b, 1'b1);
      expect_frame("echo", 0, b, 400, t);
      if (t >= 0) chk("echo_latency", {31'd0, (t - (c0 + 1)) <= BOUND && t > c0}, 32'd1);
      repeat ($urandom_range(3 * C, 0)) @(negedge clk);
    end
    chk("echo_no_ferr", {31'd0, ferr[0]}, 32'd0);
    chk("echo_no_ovf", {31'd0, ovf[0]}, 32'd0);

    // ---- false start glitch ----
    rx_line[0] = 1'b0;
    repeat (2) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (25 * C) @(negedge clk);
    chk("glitch_no_frame", n_frames(0), 0);
    chk("glitch_no_ferr", {31'd0, ferr[0]}, 32'd0);
    chk("glitch_no_ovf", {31'd0, ovf[0]}, 32'd0);
    b = 8'($urandom);
    send_byte(0, b, 1'b1);
    expect_frame("after_glitch", 0, b, 400, t);

    // ---- framing error ----
    exp_ferr0 = 1'b1;
    send_byte(0, 8'h3C, 1'b0);
    repeat (2 * C) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (25 * C) @(negedge clk);
    chk("ferr_set", {31'd0, ferr[0]}, {31'd0, exp_ferr0});
    chk("ferr_no_frame", n_frames(0), 0);
    send_byte(0, 8'h11, 1'b1);
    expect_frame("after_ferr", 0, 8'h11, 400, t);
    chk("ferr_sticky", {31'd0, ferr[0]}, {31'd0, exp_ferr0});
    chk("ferr_no_ovf", {31'd0, ovf[0]}, 32'd0);

    // ---- reset while TX is mid-frame ----
    b = 8'($urandom);
    send_byte(0, b, 1'b1);
    t = 0;
    while (tx[0] !== 1'b0 && t < 4 * C) begin @(negedge clk); t++; end
    chk("mid_frame_seen", {31'd0, tx[0]}, 32'd0);
    repeat (3 * C) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_tx", {31'd0, tx[0]}, 32'd1);
    chk("mid_rst_boot", {31'd0, boot[0]}, 32'd0);
    chk("mid_rst_ferr", {31'd0, ferr[0]}, 32'd0);
    chk("mid_rst_ovf1", {31'd0, ovf[1]}, 32'd0);
    repeat (2) @(negedge clk);
    mon_q = {};
    reset = 1'b0;
    t_rel = cyc;
    foreach (banner[i]) begin
      expect_frame("rebanner", 0, banner[i], 2000, t);
      chk("rebanner_cyc", t, t_rel + 1 + i * 10 * C);
    end
    foreach (banner[i]) expect_frame("rebanner_ovf", 1, banner[i], 2000, t);
    repeat (2 * C) @(negedge clk);
    chk("reboot_done", {31'd0, boot[0]}, 32'd1);
    all_high = 1'b1;
    repeat (3 * C) begin
      @(negedge clk);
      if (tx[0] !== 1'b1) all_high = 1'b0;
    end
    chk("idle_after_boot", {31'd0, all_high}, 32'd1);
    chk("reboot_no_frames", n_frames(0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
